// File: rtl/iir_sample_feeder.sv
// rtl/iir_sample_feeder.sv - sample FIFO and rate-paced feeder for the IIR filter input
module iir_sample_feeder #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int DIV_W     = 8,
    parameter int PRIME_LVL = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [DIV_W-1:0]           rate_div,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [DATA_W-1:0]          x,
    output logic                       x_strobe,
    output logic                       underrun,
    output logic [15:0]                underrun_cnt,
    output logic [$clog2(DEPTH):0]     level,
    output logic [1:0]                 state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             st;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   lvl;
    logic [DIV_W-1:0]   cnt;
    logic               push;
    logic               tick;
    logic               pop;

    // s_ready depends only on the registered level, never on this cycle's pop
    assign s_ready = (lvl != LVL_W'(DEPTH));
    assign push    = s_valid && s_ready;
    assign tick    = (st == RUN) && (cnt >= rate_div);
    assign pop     = tick && (lvl != '0);
    assign level   = lvl;
    assign state   = st;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st           <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lvl          <= '0;
            cnt          <= '0;
            x            <= '0;
            x_strobe     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   lvl <= lvl + LVL_W'(1);
                2'b01:   lvl <= lvl - LVL_W'(1);
                default: lvl <= lvl;
            endcase

            x_strobe <= tick;
            underrun <= tick && (lvl == '0);
            if (tick) begin
                // Starved ticks still strobe, carrying a zero sample
                x <= pop ? mem[rd_ptr] : '0;
                if ((lvl == '0) && (underrun_cnt != 16'hFFFF)) begin
                    underrun_cnt <= underrun_cnt + 16'd1;
                end
            end

            if ((st != RUN) || !enable || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end

            case (st)
                IDLE: begin
                    if (enable) st <= PRIME;
                end
                PRIME: begin
                    if (!enable)                        st <= IDLE;
                    else if (lvl >= LVL_W'(PRIME_LVL))  st <= RUN;
                end
                RUN: begin
                    if (!enable) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iir_sample_feeder.sv
// tb/tb_iir_sample_feeder.sv - directed self-checking bench for iir_sample_feeder
module tb_iir_sample_feeder;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  rate_div;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] x;
    logic        x_strobe;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic [3:0]  level;
    logic [1:0]  state;

    int total = 0;
    int fails = 0;
    int strobes;
    int gap;
    logic [15:0] v2 [5] = '{16'h060A, 16'h0414, 16'h1000, 16'h7FFF, 16'h8000};

    iir_sample_feeder dut (
        .clk(clk), .rst(rst), .enable(enable), .rate_div(rate_div),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .x(x), .x_strobe(x_strobe), .underrun(underrun),
        .underrun_cnt(underrun_cnt), .level(level), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic next_strobe(output int g);
        g = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            g++;
            if (x_strobe) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0; rate_div = '0;
        #10 rst = 1'b1;
        chk("rst_x", 32'(x), 32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h1);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_ucnt", 32'(underrun_cnt), 32'h0);
        strobes = 0;
        repeat (100) begin
            step();
            if (x_strobe) strobes++;
        end
        chk("idle_no_strobe", 32'(strobes), 32'h0);
        chk("idle_state", 32'(state), 32'h0);

        // Priming then back-to-back pops at rate_div = 0
        enable = 1'b1; rate_div = 8'd0; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = v2[i];
            step();
            chk("prime_state", 32'(state), (i < 4) ? 32'h1 : 32'h2);
            chk("prime_no_strobe", 32'(x_strobe), 32'h0);
        end
        s_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("run_x", 32'(x), 32'(v2[i]));
            chk("run_strobe", 32'(x_strobe), 32'h1);
            chk("run_level", 32'(level), 32'(4 - i));
        end
        enable = 1'b0;
        step();
        chk("urun_x", 32'(x), 32'h0);
        chk("urun_strobe", 32'(x_strobe), 32'h1);
        chk("urun_pulse", 32'(underrun), 32'h1);
        chk("urun_cnt", 32'(underrun_cnt), 32'h1);
        chk("urun_state", 32'(state), 32'h0);
        step();
        chk("urun_one_cycle", 32'(underrun), 32'h0);
        chk("strobe_one_cycle", 32'(x_strobe), 32'h0);
        chk("urun_cnt_hold", 32'(underrun_cnt), 32'h1);

        // Programmable period and mid-run rate change
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 16'h0100 + 16'(i);
            step();
        end
        s_valid = 1'b0;
        chk("fill_level", 32'(level), 32'h8);
        chk("fill_s_ready", 32'(s_ready), 32'h0);
        rate_div = 8'd3; enable = 1'b1;
        next_strobe(gap);
        chk("rate_first_gap", 32'(gap), 32'd6);
        chk("rate_x0", 32'(x), 32'h0100);
        next_strobe(gap);
        chk("rate3_gap_a", 32'(gap), 32'd4);
        chk("rate_x1", 32'(x), 32'h0101);
        next_strobe(gap);
        chk("rate3_gap_b", 32'(gap), 32'd4);
        chk("rate_x2", 32'(x), 32'h0102);
        rate_div = 8'd1;
        next_strobe(gap);
        chk("rate1_gap_a", 32'(gap), 32'd2);
        chk("rate_x3", 32'(x), 32'h0103);
        next_strobe(gap);
        chk("rate1_gap_b", 32'(gap), 32'd2);
        chk("rate_x4", 32'(x), 32'h0104);
        enable = 1'b0;
        step();
        chk("disable_state", 32'(state), 32'h0);
        chk("disable_retain_level", 32'(level), 32'h3);

        rst = 1'b0;
        #1;
        chk("rst2_level", 32'(level), 32'h0);
        #2 rst = 1'b1;
        step();

        // Full FIFO, back-pressure, then streaming with concurrent push/pop
        rate_div = 8'd0; s_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_data = 16'(i);
            step();
        end
        s_data = 16'h0009;
        repeat (3) step();
        chk("full_level", 32'(level), 32'h8);
        chk("full_s_ready", 32'(s_ready), 32'h0);
        enable = 1'b1;
        step();
        chk("full_prime", 32'(state), 32'h1);
        step();
        chk("full_run", 32'(state), 32'h2);
        chk("full_no_9th", 32'(level), 32'h8);
        for (int n = 1; n <= 32; n++) begin
            step();
            chk("stream_x", 32'(x), 32'(n));
            chk("stream_strobe", 32'(x_strobe), 32'h1);
            chk("stream_level", 32'(level), (n <= 25) ? 32'd7 : 32'(32 - n));
            if (n >= 2 && n <= 25) begin
                s_data = 16'(8 + n);
                if (n == 25) s_valid = 1'b0;
            end
        end
        step();
        chk("stream_urun", 32'(underrun), 32'h1);
        chk("stream_urun_x", 32'(x), 32'h0);
        chk("stream_urun_cnt", 32'(underrun_cnt), 32'h1);

        // Async reset mid-RUN with five buffered samples
        rate_div = 8'd200; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 16'h00A0 + 16'(i);
            step();
        end
        s_valid = 1'b0;
        chk("pre_rst_state", 32'(state), 32'h2);
        chk("pre_rst_level", 32'(level), 32'h5);
        chk("pre_rst_no_tick", 32'(x_strobe), 32'h0);
        rst = 1'b0;
        #1;
        chk("mid_rst_level", 32'(level), 32'h0);
        chk("mid_rst_x", 32'(x), 32'h0);
        chk("mid_rst_strobe", 32'(x_strobe), 32'h0);
        chk("mid_rst_state", 32'(state), 32'h0);
        chk("mid_rst_ucnt", 32'(underrun_cnt), 32'h0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'h1);
        #2 rst = 1'b1;
        step();
        enable = 1'b1; rate_div = 8'd0; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 16'h00B0 + 16'(i);
            step();
            chk("reprime_state", 32'(state), (i == 0) ? 32'h1 : 32'h1);
            chk("reprime_level", 32'(level), 32'(i + 1));
        end
        s_valid = 1'b0;
        step();
        chk("reprime_run", 32'(state), 32'h2);
        step();
        chk("reprime_first_x", 32'(x), 32'h00B0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/iir_sample_feeder.md
Name: iir_sample_feeder

Overview:
- Producer side of the IIR filter's sample interface. Upstream logic writes 16-bit samples into a small FIFO over a valid/ready handshake.
- The block presents samples on x to the filter at a programmable rate. Each new sample is marked by a one-cycle x_strobe.
- Before streaming starts, a priming threshold must be met. On starvation the block zero-stuffs x and counts underruns.
- The feeder and the filter share clk and rst.

Parameters:
- DATA_W, 16, sample width (matches filter x/y width)
- DEPTH, 8, FIFO depth in entries; power of 2, minimum 2
- DIV_W, 8, width of rate_div
- PRIME_LVL, 4, FIFO level required to leave PRIME; 1..DEPTH

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  1 = stream samples to the filter; 0 = stop
- rate_div  in  DIV_W  sample period minus 1, in clk cycles
- s_data  in  DATA_W  upstream sample
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept a sample
- x  out  DATA_W  sample to filter input, registered
- x_strobe  out  1  one-cycle pulse: x updated this cycle
- underrun  out  1  one-cycle pulse: tick occurred with FIFO empty
- underrun_cnt  out  16  saturating count of underruns
- level  out  clog2(DEPTH)+1  current FIFO occupancy
- state  out  2  current FSM state: 0 IDLE, 1 PRIME, 2 RUN

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied; pointers and level = 0; s_ready = 1.
  - x = 0, x_strobe = 0, underrun = 0, underrun_cnt = 0.
  - Tick counter = 0; state = IDLE.
  - Reset asserted mid-stream discards all buffered samples.
- Push:
  - Sample accepted when s_valid & s_ready at a rising edge.
  - s_ready = !(level == DEPTH). It is driven only from registered level, with no path from the pop side.
- Pop:
  - Occurs on a tick in RUN when level > 0.
  - The head sample is registered into x at the same edge, and x_strobe = 1 for that cycle.
  - x holds its value between strobes.
- Simultaneous push and pop: level unchanged, both operations happen.
  - Push while full is impossible (s_ready = 0), even if a pop occurs in the same cycle.
- Pop has priority over nothing. Data is never bypassed: a sample pushed in cycle N is poppable no earlier than cycle N+1.
- Tick counter (active only in RUN):
  - Counts 0,1,...; when count >= rate_div, a tick fires and count returns to 0.
  - rate_div = 0 gives a tick every cycle; rate_div = R gives a tick every R+1 cycles.
  - A change to rate_div takes effect at the next compare.
  - The first tick fires on the first RUN cycle in which count >= rate_div. Entering RUN resets count to 0.
- FSM:
  - IDLE: counter held at 0; no ticks; x holds last value. Go to PRIME when enable = 1.
  - PRIME: no ticks. Go to RUN when level >= PRIME_LVL. Go to IDLE when enable = 0.
  - RUN: ticks active. Go to IDLE when enable = 0; the counter clears and the FIFO contents are retained.
- Underrun:
  - A tick in RUN with level == 0 forces x = 0 and asserts both x_strobe and underrun for one cycle.
  - underrun_cnt increments and saturates at 0xFFFF.
  - The state stays in RUN (no re-prime).
- FIFO wrap: pointers are clog2(DEPTH) bits and wrap modulo DEPTH; level tracks occupancy 0..DEPTH.
- Latency: a sample present at the FIFO head appears on x at the tick edge, registered, with no extra pipeline stage.

Test Plan:
- Reset with rst=0 for 10 ns, then release; enable=0 -> x=0, s_ready=1, level=0, state=IDLE, no x_strobe for 100 cycles.
- enable=1, rate_div=0, push 0x060A,0x0414,0x1000,0x7FFF,0x8000 back-to-back -> state PRIME until level=4, then RUN. x_strobe pulses on consecutive cycles carrying those values in order; a 6th tick sees an empty FIFO, giving x=0, underrun pulse, underrun_cnt=1.
- rate_div=3, FIFO kept non-empty -> x_strobe exactly every 4 cycles. Change rate_div to 1 mid-run -> period becomes 2 cycles from the next tick.
- Push 8 samples with enable=0 -> level=8, s_ready=0. A 9th s_valid is held off and not accepted. Then enable=1, rate_div=0 -> samples emerge in order, and pointer wrap is exercised by continuing push/pop for 20 samples.
- Full FIFO, rate_div=0, s_valid held high -> push and pop in the same cycle keep level constant at 7/8 boundary; no sample lost or duplicated (compare sequence 0x0001..0x0020).
- Assert rst low mid-RUN with level=5 -> immediately level=0, x=0, x_strobe=0, state=IDLE, underrun_cnt=0. After release, PRIME requires 4 new samples.
